// File: rtl/dual_port_ram_param_if.sv
// dual_port_ram_param_if: request/response bundle for the two RAM ports
// Per port x in {a,b}: en_x/we_x/addr_x/din_x request, dout_x/valid_x response.
// Shared status: collision (same-address conflict strobe), busy (reset/clear active).
// master drives requests (user side); slave is the RAM.
interface dual_port_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              en_a, we_a, valid_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a, dout_a;
  logic              en_b, we_b, valid_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] din_b, dout_b;
  logic              collision, busy;
  modport master (
    output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    input  dout_a, valid_a, dout_b, valid_b, collision, busy
  );
  modport slave (
    input  en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    output dout_a, valid_a, dout_b, valid_b, collision, busy
  );
endinterface

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: true dual-port synchronous RAM with clear-after-reset
// clk, rst_n (async active-low); bus: slave side of dual_port_ram_param_if
// carrying both ports' requests, registered read data/valid, collision and busy.
module dual_port_ram_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 3,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic rst_n,
  dual_port_ram_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              act_a, act_b, wr_a, wr_b, same, col_d, col_q;
  logic [DATA_W-1:0] dat_a_q, dat_a_d, dat_b_q, dat_b_d;
  logic              val_a_q, val_a_d, val_b_q, val_b_d;
  // {valid, data} for one port; rd is the pre-write word, so a cross-port
  // reader always sees the old value.
  function automatic logic [DATA_W:0] port_next(input logic act, we,
      input logic [DATA_W-1:0] hold, rd, din);
    return !act ? {1'b0, hold} :
           !we  ? {1'b1, rd} :
           RDW_MODE == 1 ? {1'b1, din} :
           RDW_MODE == 2 ? {1'b0, hold} : {1'b1, rd};
  endfunction
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      state_d = (CLEAR_ON_RESET == 0 || ptr_q == ADDR_W'(DEPTH - 1)) ? RUN : CLEAR;
      ptr_d   = ptr_q + 1'b1;
    end
    act_a = state_q == RUN && bus.en_a;
    act_b = state_q == RUN && bus.en_b;
    wr_a  = act_a && bus.we_a;
    wr_b  = act_b && bus.we_b;
    same  = bus.addr_a == bus.addr_b;
    col_d = act_a && act_b && same && (bus.we_a || bus.we_b);
    {val_a_d, dat_a_d} = port_next(act_a, bus.we_a, dat_a_q, mem[bus.addr_a], bus.din_a);
    {val_b_d, dat_b_d} = port_next(act_b, bus.we_b, dat_b_q, mem[bus.addr_b], bus.din_b);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      dat_a_q <= '0;
      dat_b_q <= '0;
      val_a_q <= 1'b0;
      val_b_q <= 1'b0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dat_a_q <= dat_a_d;
      dat_b_q <= dat_b_d;
      val_a_q <= val_a_d;
      val_b_q <= val_b_d;
      col_q   <= col_d;
    end
  end
  // Array has no reset; port A wins a same-address double write.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR && CLEAR_ON_RESET != 0) mem[ptr_q] <= '0;
    if (wr_b && !(wr_a && same)) mem[bus.addr_b] <= bus.din_b;
    if (wr_a) mem[bus.addr_a] <= bus.din_a;
  end
  assign bus.busy = state_q == CLEAR;
  if (OUT_REG != 0) begin : g_pipe
    logic [DATA_W-1:0] dout_a_q, dout_b_q;
    logic              valid_a_q, valid_b_q, coll_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_a_q  <= '0;
        dout_b_q  <= '0;
        valid_a_q <= 1'b0;
        valid_b_q <= 1'b0;
        coll_q    <= 1'b0;
      end else begin
        dout_a_q  <= dat_a_q;
        dout_b_q  <= dat_b_q;
        valid_a_q <= val_a_q;
        valid_b_q <= val_b_q;
        coll_q    <= col_q;
      end
    end
    assign bus.dout_a    = dout_a_q;
    assign bus.dout_b    = dout_b_q;
    assign bus.valid_a   = valid_a_q;
    assign bus.valid_b   = valid_b_q;
    assign bus.collision = coll_q;
  end else begin : g_direct
    assign bus.dout_a    = dat_a_q;
    assign bus.dout_b    = dat_b_q;
    assign bus.valid_a   = val_a_q;
    assign bus.valid_b   = val_b_q;
    assign bus.collision = col_q;
  end
endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb_dual_port_ram_param: directed checks of three RAM configurations driven in lockstep
module tb_dual_port_ram_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(3)) i0 ();
  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(3)) i1 ();
  dual_port_ram_param_if #(.DATA_W(8), .ADDR_W(3)) i2 ();
  dual_port_ram_param #(.RDW_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  dual_port_ram_param #(.RDW_MODE(1), .OUT_REG(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  dual_port_ram_param #(.RDW_MODE(2), .OUT_REG(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input logic en, input logic we, input logic [2:0] addr, input logic [7:0] din);
    i0.en_a = en; i0.we_a = we; i0.addr_a = addr; i0.din_a = din;
    i1.en_a = en; i1.we_a = we; i1.addr_a = addr; i1.din_a = din;
    i2.en_a = en; i2.we_a = we; i2.addr_a = addr; i2.din_a = din;
  endtask
  task automatic set_b(input logic en, input logic we, input logic [2:0] addr, input logic [7:0] din);
    i0.en_b = en; i0.we_b = we; i0.addr_b = addr; i0.din_b = din;
    i1.en_b = en; i1.we_b = we; i1.addr_b = addr; i1.din_b = din;
    i2.en_b = en; i2.we_b = we; i2.addr_b = addr; i2.din_b = din;
  endtask
  initial begin
    int n;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) cyc();
    chk("rst_busy", 32'(i0.busy), 1);
    chk("rst_dout_a", 32'(i0.dout_a), 0);
    chk("rst_valid_a", 32'(i0.valid_a), 0);
    chk("rst_coll", 32'(i0.collision), 0);
    chk("rst_pipe_dout_b", 32'(i1.dout_b), 0);
    // requests during clear must be ignored
    rst_n = 1'b1;
    set_a(1, 1, 0, 8'hFF);
    set_b(1, 0, 0, 0);
    repeat (4) begin
      cyc();
      chk("busy_coll", 32'(i0.collision), 0);
      chk("busy_valid_b", 32'(i0.valid_b), 0);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(i0.busy), 1);
    chk("midrst_dout_a", 32'(i0.dout_a), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    n = 0;
    while (i0.busy && n < 20) begin
      cyc();
      n++;
      chk("clr_coll", 32'(i0.collision), 0);
      chk("clr_valid_a", 32'(i1.valid_a), 0);
    end
    chk("clear_len", 32'(n), 8);
    set_b(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_a(1, 0, 3'(i), 0);
      cyc();
      chk("clr_read", 32'(i0.dout_a), 0);
      chk("clr_read_v", 32'(i0.valid_a), 1);
    end
    set_a(0, 0, 0, 0);
    cyc();
    chk("idle_valid", 32'(i0.valid_a), 0);
    chk("pipe_last_v", 32'(i1.valid_a), 1);
    chk("pipe_last_d", 32'(i1.dout_a), 0);
    cyc();
    chk("pipe_idle_v", 32'(i1.valid_a), 0);
    // basic write then cross-port read
    set_a(1, 1, 3, 8'h5A);
    cyc();
    set_a(0, 0, 0, 0);
    set_b(1, 0, 3, 0);
    cyc();
    set_b(0, 0, 0, 0);
    chk("rw_dout_b", 32'(i0.dout_b), 32'h5A);
    chk("rw_valid_b", 32'(i0.valid_b), 1);
    chk("rw_pipe_early_v", 32'(i1.valid_b), 0);
    cyc();
    chk("rw_pipe_dout_b", 32'(i1.dout_b), 32'h5A);
    chk("rw_pipe_valid_b", 32'(i1.valid_b), 1);
    chk("rw_valid_b_off", 32'(i0.valid_b), 0);
    // double write collision, port A wins
    set_a(1, 1, 5, 8'h11);
    set_b(1, 1, 5, 8'h22);
    cyc();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    chk("dw_coll", 32'(i0.collision), 1);
    chk("dw_pipe_coll_early", 32'(i1.collision), 0);
    cyc();
    chk("dw_coll_once", 32'(i0.collision), 0);
    chk("dw_pipe_coll", 32'(i1.collision), 1);
    set_b(1, 0, 5, 0);
    cyc();
    set_b(0, 0, 0, 0);
    chk("dw_pipe_coll_once", 32'(i1.collision), 0);
    chk("dw_read", 32'(i0.dout_b), 32'h11);
    chk("dw_read_nochg", 32'(i2.dout_b), 32'h11);
    // cross-port read-during-write
    set_a(1, 1, 2, 8'hAA);
    cyc();
    set_a(1, 1, 2, 8'hBB);
    set_b(1, 0, 2, 0);
    cyc();
    set_a(0, 0, 0, 0);
    chk("xrdw_old", 32'(i0.dout_b), 32'hAA);
    chk("xrdw_coll", 32'(i0.collision), 1);
    cyc();
    set_b(0, 0, 0, 0);
    chk("xrdw_new", 32'(i0.dout_b), 32'hBB);
    chk("xrdw_no_coll", 32'(i0.collision), 0);
    // same-port read-during-write per mode
    set_a(1, 1, 4, 8'h01);
    cyc();
    set_a(1, 0, 3, 0);
    cyc();
    set_a(0, 0, 0, 0);
    cyc();
    set_a(1, 1, 4, 8'h02);
    cyc();
    set_a(0, 0, 0, 0);
    chk("rf_dout", 32'(i0.dout_a), 32'h01);
    chk("rf_valid", 32'(i0.valid_a), 1);
    chk("nc_dout", 32'(i2.dout_a), 32'h5A);
    chk("nc_valid", 32'(i2.valid_a), 0);
    cyc();
    chk("wf_dout", 32'(i1.dout_a), 32'h02);
    chk("wf_valid", 32'(i1.valid_a), 1);
    set_a(1, 0, 4, 0);
    cyc();
    set_a(0, 0, 0, 0);
    chk("nc_stored", 32'(i2.dout_a), 32'h02);
    chk("nc_stored_v", 32'(i2.valid_a), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
